// File: rtl/dcache_pkg.sv
// Shared widths and state encoding for the data cache sequencer.
// Defining DCACHE_CTRL_INVALIDATE_EN adds the whole-cache invalidate walk state.
package dcache_pkg;

    localparam int unsigned LineWidth = 148;
    localparam int unsigned DataWidth = 128;
    localparam int unsigned TagWidth  = 20;
    localparam int unsigned TagMsb    = 147;
    localparam int unsigned TagLsb    = 128;
    localparam int unsigned CtrlWidth = 11;
    localparam int unsigned NumWays   = 4;
    localparam int unsigned WayWidth  = $clog2(NumWays);
    // Set index is address[IdxLsb +: SETS_LOG2]; bits below it address bytes in the line.
    localparam int unsigned IdxLsb    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StCheck,
        StWriteback,
        StFill,
        StUpdate
`ifdef DCACHE_CTRL_INVALIDATE_EN
        ,
        StInvd
`endif
    } state_e;

endpackage

// File: rtl/dcache_merge.sv
// Byte-enable merge of one 32-bit dword into a 128-bit cache line.
module dcache_merge
    import dcache_pkg::*;
(
    input  logic [DataWidth-1:0] line_i,
    input  logic [31:0]          wrdata_i,
    input  logic [3:0]           byteena_i,
    input  logic [1:0]           dword_sel_i,
    output logic [DataWidth-1:0] line_o
);

    always_comb begin
        line_o = line_i;
        for (int b = 0; b < 4; b++) begin
            if (byteena_i[b]) begin
                line_o[{dword_sel_i, b[1:0], 3'd0} +: 8] = wrdata_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Sequencer for a 4-way write-back/write-allocate data cache: lookup, victim writeback,
// line fill and set update. DCACHE_CTRL_INVALIDATE_EN adds invd_do/invd_done.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned SETS_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_read_do,
    input  logic                 req_write_do,
    input  logic [31:0]          req_address,
    input  logic [31:0]          req_wrdata,
    input  logic [3:0]           req_byteena,
    output logic                 req_done,
    output logic [31:0]          req_rddata,
    output logic [SETS_LOG2-1:0] ram_address,
    output logic                 ram_read,
    output logic                 ram_write,
    output logic [WayWidth-1:0]  ram_wr_way,
    output logic [LineWidth-1:0] ram_wr_line,
    output logic [CtrlWidth-1:0] ram_wr_control,
    input  logic [CtrlWidth-1:0] ram_control_q,
    input  logic                 mt_matched,
    input  logic [WayWidth-1:0]  mt_matched_index,
    input  logic [DataWidth-1:0] mt_matched_data_line,
    input  logic [WayWidth-1:0]  mt_plru_index,
    input  logic [LineWidth-1:0] mt_plru_data_line,
    input  logic                 mt_writeback_needed,
    input  logic [CtrlWidth-1:0] mt_control_after_match,
    input  logic [CtrlWidth-1:0] mt_control_after_line_read,
    input  logic [CtrlWidth-1:0] mt_control_after_write_to_existing,
    input  logic [CtrlWidth-1:0] mt_control_after_write_to_new,
    output logic                 mem_wb_do,
    output logic [31:0]          mem_wb_address,
    output logic [DataWidth-1:0] mem_wb_data,
    input  logic                 mem_wb_done,
    output logic                 mem_fill_do,
    output logic [31:0]          mem_fill_address,
    input  logic                 mem_fill_done,
    input  logic [DataWidth-1:0] mem_fill_data
`ifdef DCACHE_CTRL_INVALIDATE_EN
    ,
    input  logic                 invd_do,
    output logic                 invd_done
`endif
);

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wrdata_q, wrdata_d;
    logic [3:0]             byteena_q, byteena_d;
    logic                   is_write_q, is_write_d;
    logic [WayWidth-1:0]    way_q, way_d;
    logic [LineWidth-1:0]   line_q, line_d;
    logic [CtrlWidth-1:0]   ctrl_q, ctrl_d;
    logic [31:0]            rddata_q, rddata_d;
    logic                   wb_first_q, wb_first_d;
    logic                   ignore_q, ignore_d;
`ifdef DCACHE_CTRL_INVALIDATE_EN
    logic [SETS_LOG2-1:0]   invd_idx_q, invd_idx_d;
    logic                   invd_done_q, invd_done_d;
`endif

    logic [SETS_LOG2-1:0]   idx;
    logic [1:0]             sel;
    logic [TagWidth-1:0]    req_tag;
    logic [DataWidth-1:0]   merge_in, merged_line;
    logic                   unused_bits;

    assign idx         = addr_q[IdxLsb +: SETS_LOG2];
    assign sel         = addr_q[3:2];
    assign req_tag     = addr_q[31:32-TagWidth];
    // The matcher owns the control word; only it needs ram_control_q.
    assign unused_bits = ^{ram_control_q, addr_q[1:0]};
    assign merge_in    = (state_q == StFill) ? mem_fill_data : mt_matched_data_line;

    dcache_merge u_merge (
        .line_i      (merge_in),
        .wrdata_i    (wrdata_q),
        .byteena_i   (byteena_q),
        .dword_sel_i (sel),
        .line_o      (merged_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wrdata_q    <= '0;
            byteena_q   <= '0;
            is_write_q  <= 1'b0;
            way_q       <= '0;
            line_q      <= '0;
            ctrl_q      <= '0;
            rddata_q    <= '0;
            wb_first_q  <= 1'b0;
            ignore_q    <= 1'b0;
`ifdef DCACHE_CTRL_INVALIDATE_EN
            invd_idx_q  <= '0;
            invd_done_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            byteena_q   <= byteena_d;
            is_write_q  <= is_write_d;
            way_q       <= way_d;
            line_q      <= line_d;
            ctrl_q      <= ctrl_d;
            rddata_q    <= rddata_d;
            wb_first_q  <= wb_first_d;
            ignore_q    <= ignore_d;
`ifdef DCACHE_CTRL_INVALIDATE_EN
            invd_idx_q  <= invd_idx_d;
            invd_done_q <= invd_done_d;
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        wrdata_d         = wrdata_q;
        byteena_d        = byteena_q;
        is_write_d       = is_write_q;
        way_d            = way_q;
        line_d           = line_q;
        ctrl_d           = ctrl_q;
        rddata_d         = rddata_q;
        wb_first_d       = 1'b0;
        ignore_d         = 1'b0;
`ifdef DCACHE_CTRL_INVALIDATE_EN
        invd_idx_d       = invd_idx_q;
        invd_done_d      = 1'b0;
`endif
        req_done         = 1'b0;
        req_rddata       = '0;
        ram_address      = '0;
        ram_read         = 1'b0;
        ram_write        = 1'b0;
        ram_wr_way       = '0;
        ram_wr_line      = '0;
        ram_wr_control   = '0;
        mem_wb_do        = 1'b0;
        mem_wb_address   = '0;
        mem_wb_data      = '0;
        mem_fill_do      = 1'b0;
        mem_fill_address = '0;

        unique case (state_q)
            StIdle: begin
`ifdef DCACHE_CTRL_INVALIDATE_EN
                if (invd_do) begin
                    invd_idx_d = '0;
                    state_d    = StInvd;
                end else
`endif
                // The requester still drives its old request in the cycle after req_done.
                if (!ignore_q && (req_write_do || req_read_do)) begin
                    addr_d     = req_address;
                    wrdata_d   = req_wrdata;
                    byteena_d  = req_byteena;
                    is_write_d = req_write_do;
                    state_d    = StLookup;
                end
            end
            StLookup: begin
                ram_read    = 1'b1;
                ram_address = idx;
                state_d     = StCheck;
            end
            StCheck: begin
                if (mt_matched) begin
                    way_d   = mt_matched_index;
                    state_d = StUpdate;
                    if (is_write_q) begin
                        line_d = {req_tag, merged_line};
                        ctrl_d = mt_control_after_write_to_existing;
                    end else begin
                        line_d   = {req_tag, mt_matched_data_line};
                        rddata_d = mt_matched_data_line[{sel, 5'd0} +: 32];
                        ctrl_d   = mt_control_after_match;
                    end
                end else begin
                    way_d  = mt_plru_index;
                    line_d = mt_plru_data_line;
                    ctrl_d = is_write_q ? mt_control_after_write_to_new
                                        : mt_control_after_line_read;
                    if (mt_writeback_needed) begin
                        wb_first_d = 1'b1;
                        state_d    = StWriteback;
                    end else begin
                        state_d    = StFill;
                    end
                end
            end
            StWriteback: begin
                mem_wb_do      = 1'b1;
                mem_wb_address = {line_q[TagMsb:TagLsb], idx, 4'h0};
                mem_wb_data    = line_q[DataWidth-1:0];
                if (!wb_first_q && mem_wb_done) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                mem_fill_do      = 1'b1;
                mem_fill_address = {addr_q[31:4], 4'h0};
                if (mem_fill_done) begin
                    line_d   = {req_tag, is_write_q ? merged_line : mem_fill_data};
                    rddata_d = mem_fill_data[{sel, 5'd0} +: 32];
                    state_d  = StUpdate;
                end
            end
            StUpdate: begin
                ram_write      = 1'b1;
                ram_address    = idx;
                ram_wr_way     = way_q;
                ram_wr_line    = line_q;
                ram_wr_control = ctrl_q;
                req_done       = 1'b1;
                req_rddata     = rddata_q;
                ignore_d       = 1'b1;
                state_d        = StIdle;
            end
`ifdef DCACHE_CTRL_INVALIDATE_EN
            StInvd: begin
                ram_write   = 1'b1;
                ram_address = invd_idx_q;
                invd_idx_d  = invd_idx_q + 1'b1;
                if (&invd_idx_q) begin
                    invd_done_d = 1'b1;
                    state_d     = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifdef DCACHE_CTRL_INVALIDATE_EN
    assign invd_done = invd_done_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: the bench plays matcher and memory, queues the expected
// set update and memory requests per transaction, and monitors compare as the DUT presents them.
module tb_dcache_ctrl;

    logic         clk;
    logic         rst;
    logic         req_read_do, req_write_do;
    logic [31:0]  req_address, req_wrdata;
    logic [3:0]   req_byteena;
    logic         req_done;
    logic [31:0]  req_rddata;
    logic [7:0]   ram_address;
    logic         ram_read, ram_write;
    logic [1:0]   ram_wr_way;
    logic [147:0] ram_wr_line;
    logic [10:0]  ram_wr_control;
    logic [10:0]  ram_control_q;
    logic         mt_matched;
    logic [1:0]   mt_matched_index;
    logic [127:0] mt_matched_data_line;
    logic [1:0]   mt_plru_index;
    logic [147:0] mt_plru_data_line;
    logic         mt_writeback_needed;
    logic [10:0]  mt_control_after_match, mt_control_after_line_read;
    logic [10:0]  mt_control_after_write_to_existing, mt_control_after_write_to_new;
    logic         mem_wb_do, mem_wb_done;
    logic [31:0]  mem_wb_address;
    logic [127:0] mem_wb_data;
    logic         mem_fill_do, mem_fill_done;
    logic [31:0]  mem_fill_address;
    logic [127:0] mem_fill_data;
`ifdef DCACHE_CTRL_INVALIDATE_EN
    logic         invd_do, invd_done;
`endif

    dcache_ctrl #(.SETS_LOG2(8)) dut (
        .clk                                (clk),
        .rst                                (rst),
        .req_read_do                        (req_read_do),
        .req_write_do                       (req_write_do),
        .req_address                        (req_address),
        .req_wrdata                         (req_wrdata),
        .req_byteena                        (req_byteena),
        .req_done                           (req_done),
        .req_rddata                         (req_rddata),
        .ram_address                        (ram_address),
        .ram_read                           (ram_read),
        .ram_write                          (ram_write),
        .ram_wr_way                         (ram_wr_way),
        .ram_wr_line                        (ram_wr_line),
        .ram_wr_control                     (ram_wr_control),
        .ram_control_q                      (ram_control_q),
        .mt_matched                         (mt_matched),
        .mt_matched_index                   (mt_matched_index),
        .mt_matched_data_line               (mt_matched_data_line),
        .mt_plru_index                      (mt_plru_index),
        .mt_plru_data_line                  (mt_plru_data_line),
        .mt_writeback_needed                (mt_writeback_needed),
        .mt_control_after_match             (mt_control_after_match),
        .mt_control_after_line_read         (mt_control_after_line_read),
        .mt_control_after_write_to_existing (mt_control_after_write_to_existing),
        .mt_control_after_write_to_new      (mt_control_after_write_to_new),
        .mem_wb_do                          (mem_wb_do),
        .mem_wb_address                     (mem_wb_address),
        .mem_wb_data                        (mem_wb_data),
        .mem_wb_done                        (mem_wb_done),
        .mem_fill_do                        (mem_fill_do),
        .mem_fill_address                   (mem_fill_address),
        .mem_fill_done                      (mem_fill_done),
        .mem_fill_data                      (mem_fill_data)
`ifdef DCACHE_CTRL_INVALIDATE_EN
        ,
        .invd_do                            (invd_do),
        .invd_done                          (invd_done)
`endif
    );

    typedef struct {
        logic [31:0]  rddata;
        logic         chk_rd;
        logic [1:0]   way;
        logic [147:0] line;
        logic [10:0]  ctrl;
        logic [7:0]   idx;
        int           done_cyc;
    } exp_req_t;

    typedef struct {
        logic         is_wb;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_mem_t;

    exp_req_t req_q[$];
    exp_mem_t mem_q[$];
    exp_req_t mon_e;
    exp_mem_t mem_e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fill_wait = 0;
    int wb_cnt = 0;
    int fill_cnt = 0;
    logic [127:0] fill_line;
    bit  invd_active = 0;
    int  invd_writes = 0;
    int  invd_dones = 0;

    localparam logic [10:0] CtlMatch = 11'h2A5;
    localparam logic [10:0] CtlLineRd = 11'h111;
    localparam logic [10:0] CtlWrExist = 11'h0F3;
    localparam logic [10:0] CtlWrNew = 11'h3C7;
    localparam logic [127:0] LineHit = 128'h33333333_22222222_DEADBEEF_11111111;
    localparam logic [127:0] LineL2 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [147:0] Victim = {20'hFEDCB, 128'h0123456789ABCDEF_FEDCBA9876543210};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_req_t mk_req(input logic [31:0] rd, input logic chk, input logic [1:0] way,
                                        input logic [147:0] line, input logic [10:0] ctrl,
                                        input logic [7:0] idx);
        exp_req_t e;
        e.rddata = rd; e.chk_rd = chk; e.way = way; e.line = line;
        e.ctrl = ctrl; e.idx = idx; e.done_cyc = 0;
        return e;
    endfunction

    function automatic exp_mem_t mk_mem(input logic wb, input logic [31:0] a, input logic [127:0] d);
        exp_mem_t m;
        m.is_wb = wb; m.addr = a; m.data = d;
        return m;
    endfunction

    task automatic set_match(input logic hit, input logic [1:0] hidx, input logic [127:0] hline,
                             input logic [1:0] pidx, input logic [147:0] pline, input logic wbn);
        mt_matched = hit; mt_matched_index = hidx; mt_matched_data_line = hline;
        mt_plru_index = pidx; mt_plru_data_line = pline; mt_writeback_needed = wbn;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: req_done stayed 0 for 40 cycles, expected 1", name);
            req_q.delete();
            mem_q.delete();
        end
    endtask

    // lat counts the request-sample edge as cycle 0's start, so a hit has lat 3.
    task automatic run_req(input string name, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input exp_req_t e_in,
                           input int lat);
        exp_req_t e = e_in;
        @(negedge clk);
        e.done_cyc = cyc + lat;
        req_q.push_back(e);
        req_write_do = wr; req_read_do = !wr;
        req_address = addr; req_wrdata = wd; req_byteena = be;
        wait_done(name);
        @(negedge clk);
        req_write_do = 1'b0; req_read_do = 1'b0;
    endtask

    // Set-update monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_read) begin
                if (req_q.size() > 0) check("lookup_index", ram_address, req_q[0].idx);
                else begin
                    checks++; errors++;
                    $display("FAIL unexpected_lookup: ram_read=1 with nothing pending, expected 0");
                end
            end
`ifdef DCACHE_CTRL_INVALIDATE_EN
            if (invd_done) begin
                invd_dones++;
                if (!invd_active) begin
                    checks++; errors++;
                    $display("FAIL unexpected_invd_done: invd_done=1 without invd_do, expected 0");
                end
            end
            if (invd_active && ram_write && !req_done) begin
                check("invd_write", {ram_address, ram_wr_control}, {invd_writes[7:0], 11'd0});
                invd_writes++;
            end else
`endif
            if (req_done || ram_write) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update: req_done=%0b ram_write=%0b with nothing pending, expected 0 0",
                             req_done, ram_write);
                end else begin
                    mon_e = req_q.pop_front();
                    check("done_and_write", {req_done, ram_write}, 2'b11);
                    check("wr_way", ram_wr_way, mon_e.way);
                    check("wr_line", ram_wr_line, mon_e.line);
                    check("wr_control", ram_wr_control, mon_e.ctrl);
                    check("wr_index", ram_address, mon_e.idx);
                    check("latency_cycle", cyc, mon_e.done_cyc);
                    if (mon_e.chk_rd) check("rddata", req_rddata, mon_e.rddata);
                end
            end
        end
    end

    // Memory responder: writeback ack pulses in the first cycle (must be ignored) and the third.
    always @(negedge clk) begin
        mem_wb_done = 1'b0;
        mem_fill_done = 1'b0;
        if (mem_wb_do && !rst) begin
            if (wb_cnt == 0) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: mem_wb_do=1 addr %0h, expected no request", mem_wb_address);
                end else begin
                    mem_e = mem_q.pop_front();
                    check("wb_request", {1'b1, mem_wb_address, mem_wb_data},
                          {mem_e.is_wb, mem_e.addr, mem_e.data});
                end
            end
            if (wb_cnt == 0 || wb_cnt == 2) mem_wb_done = 1'b1;
            wb_cnt++;
        end else wb_cnt = 0;
        if (mem_fill_do && !rst) begin
            if (fill_cnt == 0) begin
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_fill: mem_fill_do=1 addr %0h, expected no request", mem_fill_address);
                end else begin
                    mem_e = mem_q.pop_front();
                    check("fill_request", {1'b0, mem_fill_address}, {mem_e.is_wb, mem_e.addr});
                end
            end
            if (fill_cnt == fill_wait) begin
                mem_fill_done = 1'b1;
                mem_fill_data = fill_line;
            end
            fill_cnt++;
        end else fill_cnt = 0;
    end

    initial begin
        bit seen;
        exp_req_t ew, er;
        rst = 1'b1;
        req_read_do = 0; req_write_do = 0; req_address = '0; req_wrdata = '0; req_byteena = '0;
        ram_control_q = 11'h0;
        mem_fill_data = '0; fill_line = '0;
        mt_control_after_match = CtlMatch;
        mt_control_after_line_read = CtlLineRd;
        mt_control_after_write_to_existing = CtlWrExist;
        mt_control_after_write_to_new = CtlWrNew;
        set_match(0, 0, '0, 0, '0, 0);
`ifdef DCACHE_CTRL_INVALIDATE_EN
        invd_do = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_ctrl", {req_done, ram_read, ram_write, mem_wb_do, mem_fill_do, ram_address,
                             ram_wr_way, ram_wr_control, req_rddata, mem_fill_address}, '0);
        check("reset_line", ram_wr_line, '0);
        check("reset_wb_bus", {mem_wb_address, mem_wb_data}, '0);
        rst = 1'b0;

        // Read hit, way 2, dword 1.
        set_match(1, 2, LineHit, 0, '0, 0);
        run_req("read_hit", 0, 32'h12345A14, 32'h0, 4'h0,
                mk_req(32'hDEADBEEF, 1, 2, {20'h12345, LineHit}, CtlMatch, 8'hA1), 3);

        // Write hit, low half of dword 0 in way 0.
        set_match(1, 0, LineL2, 0, '0, 0);
        run_req("write_hit", 1, 32'h12345A10, 32'hAAAA5555, 4'b0011,
                mk_req(32'h0, 0, 0, {20'h12345, 128'h44444444_33333333_22222222_11115555},
                       CtlWrExist, 8'hA1), 3);

        // Clean read miss, fill acked after two wait cycles.
        set_match(0, 0, '0, 3, {20'h55555, 128'h0}, 0);
        fill_wait = 2;
        fill_line = 128'hCAFE0003_BEEF0002_F00D0001_D00D0000;
        mem_q.push_back(mk_mem(0, 32'h0ABCD7F0, '0));
        run_req("clean_miss", 0, 32'h0ABCD7F8, 32'h0, 4'h0,
                mk_req(32'hBEEF0002, 1, 3, {20'h0ABCD, fill_line}, CtlLineRd, 8'h7F), 6);

        // Dirty-victim write miss: writeback, then fill, then merged write.
        set_match(0, 0, '0, 1, Victim, 1);
        fill_wait = 0;
        fill_line = 128'h11223344_55667788_99AABBCC_DDEEFF00;
        mem_q.push_back(mk_mem(1, 32'hFEDCB210, Victim[127:0]));
        mem_q.push_back(mk_mem(0, 32'h76543210, '0));
        run_req("dirty_miss", 1, 32'h7654321C, 32'h89ABCDEF, 4'b1010,
                mk_req(32'h0, 0, 1, {20'h76543, 128'h8922CD44_55667788_99AABBCC_DDEEFF00},
                       CtlWrNew, 8'h21), 7);

        // Reset while waiting in FILL aborts the transaction.
        set_match(0, 0, '0, 3, {20'h55555, 128'h0}, 0);
        fill_wait = 1000;
        mem_q.push_back(mk_mem(0, 32'h0ABCD7F0, '0));
        @(negedge clk);
        req_q.push_back(mk_req(32'h0, 0, 3, '0, CtlLineRd, 8'h7F));
        req_read_do = 1'b1; req_address = 32'h0ABCD7F8;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_fill_do) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL abort_fill_timeout: mem_fill_do stayed 0 for 20 cycles, expected 1");
        end
        @(negedge clk);
        rst = 1'b1; req_read_do = 1'b0;
        req_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {mem_fill_do, req_done, ram_write, ram_read}, 4'b0000);
        repeat (3) @(negedge clk);
        fill_wait = 0;

        // Normal request after the aborted one.
        set_match(1, 2, LineHit, 0, '0, 0);
        run_req("hit_after_reset", 0, 32'h12345A14, 32'h0, 4'h0,
                mk_req(32'hDEADBEEF, 1, 2, {20'h12345, LineHit}, CtlMatch, 8'hA1), 3);

        // Write and read together: write first, read served after the post-done idle cycle.
        set_match(1, 0, LineL2, 0, '0, 0);
        ew = mk_req(32'h0, 0, 0, {20'h12345, 128'h44444444_33333333_22222222_11115555},
                    CtlWrExist, 8'hA1);
        er = mk_req(32'h22222222, 1, 0, {20'h12345, LineL2}, CtlMatch, 8'hA1);
        @(negedge clk);
        ew.done_cyc = cyc + 3;
        er.done_cyc = cyc + 8;
        req_q.push_back(ew);
        req_q.push_back(er);
        req_write_do = 1'b1; req_read_do = 1'b1;
        req_address = 32'h12345A10; req_wrdata = 32'hAAAA5555; req_byteena = 4'b0011;
        wait_done("dual_write");
        @(negedge clk);
        req_write_do = 1'b0; req_address = 32'h12345A14;
        wait_done("dual_read");
        @(negedge clk);
        req_read_do = 1'b0;

`ifdef DCACHE_CTRL_INVALIDATE_EN
        @(negedge clk);
        invd_active = 1; invd_writes = 0; invd_dones = 0;
        invd_do = 1'b1;
        @(negedge clk);
        invd_do = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (invd_dones > 0) break;
        end
        repeat (3) @(negedge clk);
        check("invd_write_count", invd_writes, 256);
        check("invd_done_count", invd_dones, 1);
        invd_active = 0;
        set_match(0, 0, '0, 3, {20'h55555, 128'h0}, 0);
        fill_line = 128'hCAFE0003_BEEF0002_F00D0001_D00D0000;
        mem_q.push_back(mk_mem(0, 32'h0ABCD7F0, '0));
        run_req("miss_after_invd", 0, 32'h0ABCD7F8, 32'h0, 4'h0,
                mk_req(32'hBEEF0002, 1, 3, {20'h0ABCD, fill_line}, CtlLineRd, 8'h7F), 4);
`endif

        repeat (5) @(negedge clk);
        check("req_queue_drained", req_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
